// File: rtl/uart_pkt_parser_if.sv
// uart_pkt_parser_if: rx FIFO pop, payload stream and tx FIFO response signals of uart_pkt_parser.
interface uart_pkt_parser_if #(parameter int FIFO_WIDTH = 8);
    logic [FIFO_WIDTH-1:0] in_data;
    logic [FIFO_WIDTH-1:0] pkt_data;
    logic [FIFO_WIDTH-1:0] tx_wr_data;
    logic in_valid;
    logic in_rd;
    logic pkt_valid;
    logic pkt_ready;
    logic pkt_last;
    logic pkt_done;
    logic pkt_ok;
    logic tx_wr;
    logic tx_full;
    modport master (
        input in_data, in_valid, pkt_ready, tx_full,
        output in_rd, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_ok, tx_wr_data, tx_wr
    );
    modport slave (
        output in_data, in_valid, pkt_ready, tx_full,
        input in_rd, pkt_data, pkt_valid, pkt_last, pkt_done, pkt_ok, tx_wr_data, tx_wr
    );
endinterface

// File: rtl/uart_pkt_parser.sv
// uart_pkt_parser: SOF/LEN/payload/XOR-checksum frame decoder with ACK/NAK reply to the tx FIFO.
// Defining UART_PKT_TIMEOUT_EN aborts a frame after TIMEOUT_CYCLES without a new byte.
module uart_pkt_parser #(
    parameter int FIFO_WIDTH = 8,
    parameter logic [FIFO_WIDTH-1:0] SOF_BYTE = 8'hA5,
    parameter logic [FIFO_WIDTH-1:0] ACK_BYTE = 8'h06,
    parameter logic [FIFO_WIDTH-1:0] NAK_BYTE = 8'h15,
    parameter int MAX_LEN = 64,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic clk,
    input logic rst,
    uart_pkt_parser_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, RESP} state_t;
    localparam logic [FIFO_WIDTH-1:0] MAX_L = FIFO_WIDTH'(MAX_LEN);
    localparam logic [FIFO_WIDTH-1:0] ONE = FIFO_WIDTH'(1);
    state_t state, state_n;
    logic [FIFO_WIDTH-1:0] cnt;
    logic [FIFO_WIDTH-1:0] csum;
    logic [FIFO_WIDTH-1:0] resp;
    logic pay_pop;
    logic done_n;
    logic ok_n;
    logic timeout;
    // CSUM shares the payload pop gate so pkt_done never precedes acceptance of the last byte
    always_comb begin
        bus.in_rd = bus.in_valid & ((state == PAYLOAD || state == CSUM) ? (!bus.pkt_valid | bus.pkt_ready) : (state != RESP));
        bus.tx_wr = state == RESP && !bus.tx_full;
        bus.tx_wr_data = resp;
        pay_pop = bus.in_rd && state == PAYLOAD;
        state_n = state;
        done_n = 1'b0;
        ok_n = 1'b0;
        if (timeout) begin
            state_n = RESP;
            done_n = 1'b1;
        end else if (bus.in_rd) begin
            case (state)
                IDLE: state_n = bus.in_data == SOF_BYTE ? LEN : IDLE;
                LEN: begin
                    done_n = bus.in_data == '0 || bus.in_data > MAX_L;
                    state_n = done_n ? RESP : PAYLOAD;
                end
                PAYLOAD: state_n = cnt == ONE ? CSUM : PAYLOAD;
                CSUM: begin
                    state_n = RESP;
                    done_n = 1'b1;
                    ok_n = bus.in_data == csum;
                end
                default: state_n = state;
            endcase
        end else if (bus.tx_wr) begin
            state_n = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            csum <= '0;
            resp <= '0;
            bus.pkt_data <= '0;
            bus.pkt_valid <= 1'b0;
            bus.pkt_last <= 1'b0;
            bus.pkt_done <= 1'b0;
            bus.pkt_ok <= 1'b0;
        end else begin
            state <= state_n;
            bus.pkt_done <= done_n;
            bus.pkt_ok <= ok_n;
            bus.pkt_valid <= pay_pop | (bus.pkt_valid & !bus.pkt_ready);
            if (done_n) resp <= ok_n ? ACK_BYTE : NAK_BYTE;
            if (bus.in_rd && state == LEN) begin
                cnt <= bus.in_data;
                csum <= bus.in_data;
            end
            if (pay_pop) begin
                bus.pkt_data <= bus.in_data;
                bus.pkt_last <= cnt == ONE;
                csum <= csum ^ bus.in_data;
                cnt <= cnt - ONE;
            end
        end
    end
`ifdef UART_PKT_TIMEOUT_EN
    logic [31:0] idle_cnt;
    always_ff @(posedge clk) begin
        if (rst || bus.in_rd || state == IDLE || state == RESP) idle_cnt <= '0;
        else idle_cnt <= idle_cnt + 32'd1;
    end
    assign timeout = idle_cnt == 32'(TIMEOUT_CYCLES) && !bus.in_rd;
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
endmodule
